// File: rtl/sram_write_arbiter.sv
// rtl/sram_write_arbiter.sv - N-channel burst-locked write arbiter onto one SRAM request port
module sram_write_arbiter #(
  parameter int N_CH      = 4,
  parameter int ADDR_W    = 18,
  parameter int DATA_W    = 32,
  parameter int MASK_W    = 4,
  parameter int BURST_LEN = 8,
  parameter int RR_MODE   = 1,
  localparam int BEAT_W   = MASK_W + ADDR_W + DATA_W,
  localparam int GID_W    = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [N_CH*BEAT_W-1:0]   ch_din,
  input  logic [N_CH-1:0]          ch_din_valid,
  output logic [N_CH-1:0]          ch_din_ready,
  output logic                     sram_addr_valid,
  input  logic                     sram_ready,
  output logic [ADDR_W-1:0]        sram_addr,
  output logic [DATA_W-1:0]        sram_data_in,
  output logic [MASK_W-1:0]        sram_write_mask,
  output logic [GID_W-1:0]         grant_id,
  output logic                     busy
);

  typedef enum logic {S_IDLE, S_GRANT} state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [GID_W-1:0]    r_grant;
  logic [GID_W-1:0]    r_last;
  logic [7:0]          r_cnt;
  logic                r_valid;
  logic [ADDR_W-1:0]   r_addr;
  logic [DATA_W-1:0]   r_data;
  logic [MASK_W-1:0]   r_mask;

  logic                w_any;
  logic [GID_W-1:0]    w_win;
  logic [GID_W-1:0]    w_idx;
  logic                w_busy;
  logic                w_can_load;
  logic                w_sel_valid;
  logic                w_accept;
  logic                w_release;
  logic [BEAT_W-1:0]   w_sel_beat;

  assign w_any       = |ch_din_valid;
  assign w_busy      = (r_state == S_GRANT);
  assign w_can_load  = ~r_valid | sram_ready;
  assign w_sel_valid = ch_din_valid[r_grant];
  assign w_sel_beat  = ch_din[int'(r_grant)*BEAT_W +: BEAT_W];
  assign w_accept    = w_busy & w_sel_valid & w_can_load;
  assign w_release   = w_busy & w_can_load &
                       (~w_sel_valid | (r_cnt == 8'(BURST_LEN - 1)));

  // Loops run in reverse search order so the last hit is the first candidate.
  always_comb begin
    w_win = '0;
    w_idx = '0;
    if (RR_MODE != 0) begin
      for (int k = N_CH; k >= 1; k--) begin
        w_idx = GID_W'((int'(r_last) + k) % N_CH);
        if (ch_din_valid[w_idx]) w_win = w_idx;
      end
    end else begin
      for (int i = N_CH - 1; i >= 0; i--) begin
        if (ch_din_valid[i]) w_win = GID_W'(i);
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_any)     w_state_nxt = S_GRANT;
      S_GRANT: if (w_release) w_state_nxt = S_IDLE;
      default:                w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    ch_din_ready = '0;
    if (w_busy && w_can_load) ch_din_ready[r_grant] = 1'b1;
    busy            = w_busy;
    grant_id        = r_grant;
    sram_addr_valid = r_valid;
    sram_addr       = r_addr;
    sram_data_in    = r_data;
    sram_write_mask = r_mask;
  end

  // Release wins over the increment so a capped burst restarts at zero.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_grant <= '0;
      r_last  <= GID_W'(N_CH - 1);
      r_cnt   <= '0;
      r_valid <= 1'b0;
      r_addr  <= '0;
      r_data  <= '0;
      r_mask  <= '0;
    end else begin
      if (!w_busy && w_any) r_grant <= w_win;
      if (w_accept) begin
        r_valid <= 1'b1;
        r_mask  <= w_sel_beat[BEAT_W-1 -: MASK_W];
        r_addr  <= w_sel_beat[DATA_W +: ADDR_W];
        r_data  <= w_sel_beat[DATA_W-1:0];
        r_cnt   <= r_cnt + 8'd1;
      end else if (sram_ready) begin
        r_valid <= 1'b0;
      end
      if (w_release) begin
        r_last <= r_grant;
        r_cnt  <= '0;
      end
    end
  end

endmodule

// File: tb/tb_sram_write_arbiter.sv
// tb/tb_sram_write_arbiter.sv - randomized bench for sram_write_arbiter, RR and fixed-priority instances
module tb_sram_write_arbiter;
  localparam int N  = 4;
  localparam int AW = 18;
  localparam int DW = 32;
  localparam int MW = 4;
  localparam int BL = 3;
  localparam int BW = MW + AW + DW;

  logic             clock = 1'b0;
  logic             reset;
  logic             sram_ready;
  logic [N*BW-1:0]  din  [2];
  logic [N-1:0]     dval [2];
  logic [N-1:0]     drdy [2];
  logic             ov   [2];
  logic [AW-1:0]    oaddr[2];
  logic [DW-1:0]    odata[2];
  logic [MW-1:0]    omask[2];
  logic [1:0]       gid  [2];
  logic             bsy  [2];

  always #5 clock = ~clock;

  sram_write_arbiter #(.N_CH(N), .ADDR_W(AW), .DATA_W(DW), .MASK_W(MW),
                       .BURST_LEN(BL), .RR_MODE(1)) u_rr (
    .clock(clock), .reset(reset), .ch_din(din[0]), .ch_din_valid(dval[0]),
    .ch_din_ready(drdy[0]), .sram_addr_valid(ov[0]), .sram_ready(sram_ready),
    .sram_addr(oaddr[0]), .sram_data_in(odata[0]), .sram_write_mask(omask[0]),
    .grant_id(gid[0]), .busy(bsy[0]));

  sram_write_arbiter #(.N_CH(N), .ADDR_W(AW), .DATA_W(DW), .MASK_W(MW),
                       .BURST_LEN(BL), .RR_MODE(0)) u_fp (
    .clock(clock), .reset(reset), .ch_din(din[1]), .ch_din_valid(dval[1]),
    .ch_din_ready(drdy[1]), .sram_addr_valid(ov[1]), .sram_ready(sram_ready),
    .sram_addr(oaddr[1]), .sram_data_in(odata[1]), .sram_write_mask(omask[1]),
    .grant_id(gid[1]), .busy(bsy[1]));

  int n_cmp = 0;
  int n_err = 0;

  // Reference view: a grant holder, a beat count within the grant, and a one-deep output slot.
  bit            m_busy [2];
  int            m_gid  [2];
  int            m_last [2];
  int            m_cnt  [2];
  bit            m_ov   [2];
  logic [BW-1:0] m_obeat[2];

  bit            p_valid[2][N];
  int            p_seq  [2][N];
  logic [BW-1:0] p_beat [2][N];
  int            out_seq[2][N];
  bit            acc    [2][N];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [BW-1:0] mk_beat(input int ch, input int seq);
    logic [MW-1:0] m;
    logic [AW-1:0] a;
    logic [DW-1:0] dd;
    m  = ($urandom_range(3) == 0) ? '0 : MW'($urandom);
    a  = {ch[1:0], seq[15:0]};
    dd = $urandom;
    return {m, a, dd};
  endfunction

  function automatic int pick(input logic [N-1:0] v, input int last, input bit rr);
    if (rr) begin
      for (int k = 1; k <= N; k++)
        if (v[(last + k) % N]) return (last + k) % N;
    end else begin
      for (int i = 0; i < N; i++)
        if (v[i]) return i;
    end
    return -1;
  endfunction

  task automatic model_reset(input int d);
    m_busy[d] = 0; m_gid[d] = 0; m_last[d] = N - 1; m_cnt[d] = 0;
    m_ov[d] = 0; m_obeat[d] = '0;
  endtask

  task automatic model_step(input int d);
    bit cl, took, sel;
    int w;
    took = 0;
    if (reset) begin
      model_reset(d);
      return;
    end
    cl = !m_ov[d] || sram_ready;
    if (!m_busy[d]) begin
      w = pick(dval[d], m_last[d], d == 0);
      if (w >= 0) begin m_gid[d] = w; m_busy[d] = 1; end
    end else if (cl) begin
      sel = dval[d][m_gid[d]];
      if (sel) begin
        m_obeat[d] = din[d][m_gid[d]*BW +: BW];
        took = 1;
        m_cnt[d]++;
      end
      if (!sel || m_cnt[d] == BL) begin
        m_busy[d] = 0; m_last[d] = m_gid[d]; m_cnt[d] = 0;
      end
    end
    if (took) m_ov[d] = 1;
    else if (sram_ready) m_ov[d] = 0;
  endtask

  task automatic compare(input int d);
    logic [N-1:0] er;
    int ch;
    er = '0;
    if (m_busy[d] && (!m_ov[d] || sram_ready)) er[m_gid[d]] = 1'b1;
    chk($sformatf("d%0d_ready", d), 64'(drdy[d]), 64'(er));
    chk($sformatf("d%0d_busy", d), 64'(bsy[d]), 64'(m_busy[d]));
    chk($sformatf("d%0d_grant_id", d), 64'(gid[d]), 64'(m_gid[d]));
    chk($sformatf("d%0d_addr_valid", d), 64'(ov[d]), 64'(m_ov[d]));
    chk($sformatf("d%0d_beat", d), 64'({omask[d], oaddr[d], odata[d]}), 64'(m_obeat[d]));
    if (ov[d] && sram_ready && !reset) begin
      ch = int'(oaddr[d][17:16]);
      chk($sformatf("d%0d_order_ch%0d", d, ch), 64'(oaddr[d][15:0]), 64'(out_seq[d][ch] & 'hffff));
      out_seq[d][ch]++;
    end
  endtask

  task automatic drive(input int pv, input int pr, input int prst);
    for (int d = 0; d < 2; d++) begin
      for (int ch = 0; ch < N; ch++) begin
        if (!p_valid[d][ch]) p_valid[d][ch] = ($urandom_range(99) < pv);
        else if ($urandom_range(99) < 3) p_valid[d][ch] = 0;
        din[d][ch*BW +: BW] = p_beat[d][ch];
        dval[d][ch] = p_valid[d][ch];
      end
    end
    sram_ready = ($urandom_range(99) < pr);
    reset = ($urandom_range(999) < prst);
  endtask

  task automatic run(input int cyc, input int pv, input int pr, input int prst);
    repeat (cyc) begin
      drive(pv, pr, prst);
      #1;
      for (int d = 0; d < 2; d++) begin
        compare(d);
        for (int ch = 0; ch < N; ch++) acc[d][ch] = p_valid[d][ch] && drdy[d][ch];
        model_step(d);
      end
      @(posedge clock);
      #1;
      for (int d = 0; d < 2; d++) begin
        for (int ch = 0; ch < N; ch++) begin
          if (acc[d][ch]) begin
            p_seq[d][ch]++;
            p_beat[d][ch] = mk_beat(ch, p_seq[d][ch]);
            p_valid[d][ch] = 0;
          end
          if (reset) out_seq[d][ch] = p_seq[d][ch];
        end
      end
    end
  endtask

  initial begin
    reset = 1'b1;
    sram_ready = 1'b0;
    for (int d = 0; d < 2; d++) begin
      dval[d] = '0;
      din[d]  = '0;
      model_reset(d);
      for (int ch = 0; ch < N; ch++) begin
        p_valid[d][ch] = 0;
        p_seq[d][ch]   = 0;
        out_seq[d][ch] = 0;
        p_beat[d][ch]  = mk_beat(ch, 0);
      end
    end
    @(posedge clock);
    #1;
    run(3, 0, 100, 1000);
    run(300, 80, 100, 0);
    run(300, 100, 100, 0);
    run(300, 50, 40, 5);
    run(20, 100, 0, 0);
    run(1, 100, 0, 1000);
    run(300, 100, 70, 10);
    run(300, 30, 90, 0);
    run(300, 100, 20, 0);
    run(200, 100, 100, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
